// File: rtl/img_win_ctrl_pkg.sv
// Shared opcodes, controller states and sizing helper for the image window controller.
package img_win_ctrl_pkg;

  localparam logic [3:0] OP_WRITE = 4'd0;
  localparam logic [3:0] OP_UP    = 4'd1;
  localparam logic [3:0] OP_DOWN  = 4'd2;
  localparam logic [3:0] OP_LEFT  = 4'd3;
  localparam logic [3:0] OP_RIGHT = 4'd4;
  localparam logic [3:0] OP_MAX   = 4'd5;
  localparam logic [3:0] OP_MIN   = 4'd6;
  localparam logic [3:0] OP_AVG   = 4'd7;
  localparam logic [3:0] OP_CCW   = 4'd8;
  localparam logic [3:0] OP_CW    = 4'd9;
  localparam logic [3:0] OP_MIRX  = 4'd10;
  localparam logic [3:0] OP_MIRY  = 4'd11;
  localparam logic [3:0] OP_HOME  = 4'd12;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/img_win_ctrl_if.sv
// Command, ROM-read and RAM-write signals of the image window controller.
interface img_win_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/img_win_ctrl_win_alu.sv
// Combinational 2x2 window operator: max/min/average fill, rotations and mirrors.
module win_alu
  import img_win_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ROUND = 0
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] p0,
  input  logic [DW-1:0] p1,
  input  logic [DW-1:0] p2,
  input  logic [DW-1:0] p3,
  output logic [DW-1:0] q0,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q2,
  output logic [DW-1:0] q3
);

  localparam logic [DW+1:0] RND = (ROUND != 0) ? (DW+2)'(2) : '0;

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Two guard bits keep four full-scale pixels plus the rounding bias from wrapping.
  function automatic logic [DW-1:0] avg4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + RND;
    return sum[DW+1:2];
  endfunction

  logic [DW-1:0] mx, mn, av;

  always_comb begin
    mx = max2(max2(p0, p1), max2(p2, p3));
    mn = min2(min2(p0, p1), min2(p2, p3));
    av = avg4(p0, p1, p2, p3);
    q0 = p0;
    q1 = p1;
    q2 = p2;
    q3 = p3;
    case (op)
      OP_MAX:  begin q0 = mx; q1 = mx; q2 = mx; q3 = mx; end
      OP_MIN:  begin q0 = mn; q1 = mn; q2 = mn; q3 = mn; end
      OP_AVG:  begin q0 = av; q1 = av; q2 = av; q3 = av; end
      OP_CCW:  begin q0 = p1; q1 = p3; q2 = p0; q3 = p2; end
      OP_CW:   begin q0 = p2; q1 = p0; q2 = p3; q3 = p1; end
      OP_MIRX: begin q0 = p2; q1 = p3; q2 = p0; q3 = p1; end
      OP_MIRY: begin q0 = p1; q1 = p0; q2 = p3; q3 = p2; end
      default: ;
    endcase
  end

endmodule

// File: rtl/img_win_ctrl.sv
// Image window controller: loads the image from ROM, edits a 2x2 window at a cursor,
// and streams the whole buffer to RAM on each WRITE command.
module img_win_ctrl
  import img_win_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int ROUND = 0
) (
  input logic           clk,
  input logic           reset,
  img_win_ctrl_if.slave bus
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);
  localparam int AW = XW + YW;
  localparam int N  = IMG_W * IMG_H;

  localparam logic [XW-1:0] X_HOME = XW'(IMG_W / 2 - 1);
  localparam logic [YW-1:0] Y_HOME = YW'(IMG_H / 2 - 1);
  localparam logic [XW-1:0] X_LIM  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_LIM  = YW'(IMG_H - 2);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);

  state_t        state, state_nx;
  logic [DW-1:0] pix [N];
  logic [XW-1:0] cur_x, cur_x1;
  logic [YW-1:0] cur_y, cur_y1;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [DW-1:0] q0, q1, q2, q3;
  logic          cmd_go, win_we;

  // Power-of-two sizes let the pixel address be the plain {y, x} concatenation.
  assign cur_x1 = cur_x + XW'(1);
  assign cur_y1 = cur_y + YW'(1);
  assign a0     = {cur_y,  cur_x};
  assign a1     = {cur_y,  cur_x1};
  assign a2     = {cur_y1, cur_x};
  assign a3     = {cur_y1, cur_x1};

  assign cmd_go = (state == ST_IDLE) && bus.cmd_valid && !bus.busy;
  assign win_we = cmd_go && (bus.cmd >= OP_MAX) && (bus.cmd <= OP_MIRY);

  win_alu #(.DW(DW), .ROUND(ROUND)) u_alu (
    .op (bus.cmd),
    .p0 (pix[a0]),
    .p1 (pix[a1]),
    .p2 (pix[a2]),
    .p3 (pix[a3]),
    .q0 (q0),
    .q1 (q1),
    .q2 (q2),
    .q3 (q3)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:  if (bus.IROM_A == A_LAST) state_nx = ST_IDLE;
      ST_IDLE:  if (cmd_go && bus.cmd == OP_WRITE) state_nx = ST_WRITE;
      ST_WRITE: if (bus.IRAM_A == A_LAST) state_nx = ST_IDLE;
      default:  state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.IROM_rd    <= 1'b1;
      bus.IROM_A     <= '0;
      bus.IRAM_valid <= 1'b0;
      bus.IRAM_D     <= '0;
      bus.IRAM_A     <= '0;
      bus.busy       <= 1'b1;
      bus.done       <= 1'b0;
      cur_x          <= X_HOME;
      cur_y          <= Y_HOME;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (bus.IROM_A == A_LAST) begin
            bus.IROM_rd <= 1'b0;
            bus.busy    <= 1'b0;
          end else begin
            bus.IROM_A <= bus.IROM_A + AW'(1);
          end
        end
        ST_IDLE: begin
          if (cmd_go) begin
            case (bus.cmd)
              // First beat is presented together with busy so the stream is gap-free.
              OP_WRITE: begin
                bus.busy       <= 1'b1;
                bus.IRAM_valid <= 1'b1;
                bus.IRAM_A     <= '0;
                bus.IRAM_D     <= pix[0];
              end
              OP_UP:    if (cur_y != '0)    cur_y <= cur_y - YW'(1);
              OP_DOWN:  if (cur_y != Y_LIM) cur_y <= cur_y1;
              OP_LEFT:  if (cur_x != '0)    cur_x <= cur_x - XW'(1);
              OP_RIGHT: if (cur_x != X_LIM) cur_x <= cur_x1;
              OP_HOME: begin
                cur_x <= X_HOME;
                cur_y <= Y_HOME;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          if (bus.IRAM_A == A_LAST) begin
            bus.IRAM_valid <= 1'b0;
            bus.IRAM_A     <= '0;
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
          end else begin
            bus.IRAM_A <= bus.IRAM_A + AW'(1);
            bus.IRAM_D <= pix[bus.IRAM_A + AW'(1)];
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel buffer carries data only, so it has no reset value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_LOAD) begin
        pix[bus.IROM_A] <= bus.IROM_Q;
      end else if (win_we) begin
        pix[a0] <= q0;
        pix[a1] <= q1;
        pix[a2] <= q2;
        pix[a3] <= q3;
      end
    end
  end

endmodule
